// File: rtl/imem_pkg.sv
// -----------------------------------------------------------------------------
// imem_pkg
// Shared types and constants for the instruction-memory fetch block:
//   imem_state_e : fetch FSM states (IDLE, WAIT, RESP)
//   imem_err_e   : fault code returned with every response
//   NOP_INSTR    : RISC-V canonical NOP (addi x0, x0, 0)
//   fetch_fault  : alignment / range classification of a byte address
// -----------------------------------------------------------------------------
package imem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } imem_state_e;

   typedef enum logic [1:0] {
      ERR_NONE     = 2'd0,
      ERR_MISALIGN = 2'd1,
      ERR_RANGE    = 2'd2
   } imem_err_e;

   localparam logic [31:0] NOP_INSTR = 32'h00000013;

   // Misalignment is checked first so it wins over an out-of-range address.
   // aw is the word-index width; any set bit above the index is out of range.
   function automatic imem_err_e fetch_fault(input logic [31:0] addr, input int unsigned aw);
      if (addr[1:0] != 2'b00) begin
         return ERR_MISALIGN;
      end
      if ((addr >> (aw + 2)) != 32'd0) begin
         return ERR_RANGE;
      end
      return ERR_NONE;
   endfunction

endpackage

// File: rtl/imem_array.sv
// -----------------------------------------------------------------------------
// imem_array
// DEPTH x 32-bit instruction storage with one write port and one registered,
// write-first read port. Every word powers up holding NOP_INSTR; the program
// is loaded through the write port.
// Ports:
//   clk      in   rising-edge clock
//   reset    in   async active-high reset (read register only)
//   wr_en    in   write enable
//   wr_addr  in   word index to write
//   wr_data  in   word to write
//   rd_en    in   sample the array into rd_data on this edge
//   rd_addr  in   word index to read
//   rd_data  out  registered read data
// -----------------------------------------------------------------------------
module imem_array
   import imem_pkg::*;
#(
   parameter int    DEPTH     = 64,
   parameter string INIT_FILE = ""
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [31:0]              wr_data,
   input  logic                     rd_en,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [31:0]              rd_data
);

   logic [31:0] mem [DEPTH];

   // Power-up image of the program store.
   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         mem[i] = NOP_INSTR;
      end
   end

   // NOTE: the storage array has no reset branch; clearing it would forbid RAM
   // inference and would wipe a loaded program whenever the core is reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // A write to the word being sampled on the same edge is forwarded, so the
   // response always reflects the newest program image.
   // NOTE: sequential state uses non-blocking assignments so every register
   // sees pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
      end
   end

endmodule

// File: rtl/instr_mem_fetch.sv
// -----------------------------------------------------------------------------
// instr_mem_fetch
// Request/response instruction memory for the fetch stage. One fetch may be
// outstanding; WAIT_STATES extra cycles are inserted before the array read.
// Misaligned or out-of-range addresses return NOP with a fault code. flush
// kills an in-flight fetch; prog_* loads the program in any state.
// Ports:
//   clk        in   rising-edge clock
//   reset      in   async active-high reset
//   req_valid  in   fetch request valid
//   req_ready  out  block can accept a request (IDLE)
//   req_addr   in   byte address of the instruction
//   rsp_valid  out  response valid (RESP)
//   rsp_ready  in   consumer accepts the response
//   rsp_data   out  instruction word (NOP on fault)
//   rsp_err    out  0 ok, 1 misaligned, 2 out of range
//   flush      in   abort any in-flight fetch
//   prog_we    in   program-load write enable
//   prog_addr  in   program-load word index
//   prog_data  in   program-load word
// -----------------------------------------------------------------------------
module instr_mem_fetch
   import imem_pkg::*;
#(
   parameter int    DEPTH       = 64,
   parameter int    WAIT_STATES = 0,
   parameter string INIT_FILE   = ""
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [31:0]              req_addr,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [31:0]              rsp_data,
   output logic [1:0]               rsp_err,
   input  logic                     flush,
   input  logic                     prog_we,
   input  logic [$clog2(DEPTH)-1:0] prog_addr,
   input  logic [31:0]              prog_data
);

   localparam int         AW        = $clog2(DEPTH);
   localparam logic [3:0] WAIT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

   imem_state_e state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] addr_q;
   imem_err_e   err_q;

   logic        accept;
   logic        enter_resp;
   logic [31:0] fetch_addr;
   imem_err_e   fetch_err;
   logic [31:0] arr_data;

   assign req_ready = (state_q == IDLE);
   assign rsp_valid = (state_q == RESP);
   assign accept    = req_valid && req_ready && !flush;

   // With no wait states the array is read on the accept edge itself, so the
   // live request address is used; otherwise the latched copy is.
   assign fetch_addr = (state_q == IDLE) ? req_addr : addr_q;
   assign fetch_err  = fetch_fault(fetch_addr, AW);

   // NOTE: every signal assigned here gets a default first, so no path leaves
   // one unassigned and no latch is inferred.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      enter_resp = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (WAIT_STATES == 0) begin
                  state_d    = RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_d = WAIT;
                  cnt_d   = WAIT_INIT;
               end
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d    = RESP;
               enter_resp = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // flush outranks everything, including an array read due this edge.
      if (flush) begin
         state_d    = IDLE;
         cnt_d      = 4'd0;
         enter_resp = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= '0;
         err_q   <= ERR_NONE;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            addr_q <= req_addr;
         end
         if (enter_resp) begin
            err_q <= fetch_err;
         end
      end
   end

   // A faulting fetch never indexes the array; its data is forced to NOP.
   imem_array #(
      .DEPTH     (DEPTH),
      .INIT_FILE (INIT_FILE)
   ) u_array (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (prog_we),
      .wr_addr (prog_addr),
      .wr_data (prog_data),
      .rd_en   (enter_resp && (fetch_err == ERR_NONE)),
      .rd_addr (fetch_addr[AW+1:2]),
      .rd_data (arr_data)
   );

   assign rsp_err  = err_q;
   assign rsp_data = (err_q != ERR_NONE) ? NOP_INSTR : arr_data;

endmodule

// File: tb/tb_instr_mem_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_mem_fetch
// Three instances (WAIT_STATES = 0, 2, 3) with independent stimulus, sharing
// clock and reset. Each scenario task drives one instance and compares its
// outputs against hand-computed values.
// -----------------------------------------------------------------------------
module tb_instr_mem_fetch;

   localparam logic [31:0] NOP = 32'h00000013;

   function automatic int ws_of(input int d);
      return (d == 0) ? 0 : ((d == 1) ? 2 : 3);
   endfunction

   logic        clk;
   logic        reset;
   logic        req_valid [3];
   logic        req_ready [3];
   logic [31:0] req_addr  [3];
   logic        rsp_valid [3];
   logic        rsp_ready [3];
   logic [31:0] rsp_data  [3];
   logic [1:0]  rsp_err   [3];
   logic        flush     [3];
   logic        prog_we   [3];
   logic [5:0]  prog_addr [3];
   logic [31:0] prog_data [3];

   int errors = 0;
   int checks = 0;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      instr_mem_fetch #(
         .DEPTH       (64),
         .WAIT_STATES (ws_of(g)),
         .INIT_FILE   ("")
      ) u_dut (
         .clk       (clk),
         .reset     (reset),
         .req_valid (req_valid[g]),
         .req_ready (req_ready[g]),
         .req_addr  (req_addr[g]),
         .rsp_valid (rsp_valid[g]),
         .rsp_ready (rsp_ready[g]),
         .rsp_data  (rsp_data[g]),
         .rsp_err   (rsp_err[g]),
         .flush     (flush[g]),
         .prog_we   (prog_we[g]),
         .prog_addr (prog_addr[g]),
         .prog_data (prog_data[g])
      );
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic prog(input int d, input logic [5:0] idx, input logic [31:0] data);
      prog_we[d]   = 1'b1;
      prog_addr[d] = idx;
      prog_data[d] = data;
      tick();
      prog_we[d]   = 1'b0;
   endtask

   // Full fetch with rsp_ready held high: checks latency, data, fault code and
   // the return to IDLE after the handshake. The wait for rsp_valid is bounded.
   task automatic fetch(input int d, input logic [31:0] addr, input logic [31:0] exp_data,
                        input logic [1:0] exp_err, input string name);
      int n;
      bit seen;
      req_valid[d] = 1'b1;
      req_addr[d]  = addr;
      rsp_ready[d] = 1'b1;
      tick();
      req_valid[d] = 1'b0;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 20) begin
         if (rsp_valid[d] === 1'b1) seen = 1'b1;
         else begin
            tick();
            n++;
         end
      end
      checks++;
      if (!seen || n != ws_of(d)) begin
         errors++;
         $display("FAIL %s latency: seen=%0d after %0d cycles, expected after %0d", name, seen, n, ws_of(d));
      end
      checks++;
      if (rsp_data[d] !== exp_data) begin
         errors++;
         $display("FAIL %s data: got %h expected %h", name, rsp_data[d], exp_data);
      end
      checks++;
      if (rsp_err[d] !== exp_err) begin
         errors++;
         $display("FAIL %s err: got %0d expected %0d", name, rsp_err[d], exp_err);
      end
      tick();
      checks++;
      if (rsp_valid[d] !== 1'b0 || req_ready[d] !== 1'b1) begin
         errors++;
         $display("FAIL %s idle: rsp_valid=%b req_ready=%b expected 0/1", name, rsp_valid[d], req_ready[d]);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      for (int d = 0; d < 3; d++) begin
         req_valid[d] = 1'b0; req_addr[d]  = '0; rsp_ready[d] = 1'b0; flush[d] = 1'b0;
         prog_we[d]   = 1'b0; prog_addr[d] = '0; prog_data[d] = '0;
      end
      #2 reset = 1'b1;
      tick();
      tick();
      for (int d = 0; d < 3; d++) begin
         checks++;
         if (req_ready[d] !== 1'b1 || rsp_valid[d] !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs[%0d]: req_ready=%b rsp_valid=%b expected 1/0", d, req_ready[d], rsp_valid[d]);
         end
         checks++;
         if (rsp_data[d] !== 32'h0 || rsp_err[d] !== 2'd0) begin
            errors++;
            $display("FAIL reset_rsp[%0d]: data=%h err=%0d expected 0/0", d, rsp_data[d], rsp_err[d]);
         end
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_basic_fetch();
      prog(0, 6'd1, 32'h401184b3);
      fetch(0, 32'h4, 32'h401184b3, 2'd0, "ws0_word1");
      prog(0, 6'd63, 32'h00b50533);
      fetch(0, 32'hFC, 32'h00b50533, 2'd0, "ws0_last_word");
   endtask

   task automatic test_stall();
      prog(2, 6'd0, 32'h00520333);
      req_valid[2] = 1'b1; req_addr[2] = 32'h0; rsp_ready[2] = 1'b0;
      tick();
      req_valid[2] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (rsp_valid[2] !== 1'b0 || req_ready[2] !== 1'b0) begin
            errors++;
            $display("FAIL stall_wait%0d: rsp_valid=%b req_ready=%b expected 0/0", i, rsp_valid[2], req_ready[2]);
         end
         tick();
      end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (rsp_valid[2] !== 1'b1 || rsp_data[2] !== 32'h00520333 || req_ready[2] !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold%0d: valid=%b data=%h ready=%b expected 1/00520333/0",
                     i, rsp_valid[2], rsp_data[2], req_ready[2]);
         end
         tick();
      end
      checks++;
      if (rsp_valid[2] !== 1'b1 || rsp_data[2] !== 32'h00520333) begin
         errors++;
         $display("FAIL stall_final: valid=%b data=%h expected 1/00520333", rsp_valid[2], rsp_data[2]);
      end
      rsp_ready[2] = 1'b1;
      tick();
      checks++;
      if (rsp_valid[2] !== 1'b0 || req_ready[2] !== 1'b1) begin
         errors++;
         $display("FAIL stall_release: valid=%b ready=%b expected 0/1", rsp_valid[2], req_ready[2]);
      end
   endtask

   task automatic test_faults();
      fetch(0, 32'h6,   NOP, 2'd1, "fault_misalign");
      fetch(0, 32'h100, NOP, 2'd2, "fault_range");
      fetch(0, 32'h102, NOP, 2'd1, "fault_both");
      fetch(2, 32'h103, NOP, 2'd1, "fault_both_ws3");
   endtask

   task automatic test_flush();
      prog(1, 6'd2, 32'h00c58633);
      prog(1, 6'd3, 32'h00001117);
      req_valid[1] = 1'b1; req_addr[1] = 32'h8; rsp_ready[1] = 1'b1;
      tick();
      req_valid[1] = 1'b0;
      flush[1] = 1'b1;
      tick();
      flush[1] = 1'b0;
      checks++;
      if (rsp_valid[1] !== 1'b0 || req_ready[1] !== 1'b1) begin
         errors++;
         $display("FAIL flush_kill: valid=%b ready=%b expected 0/1", rsp_valid[1], req_ready[1]);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (rsp_valid[1] !== 1'b0) begin
            errors++;
            $display("FAIL flush_no_rsp%0d: rsp_valid=%b expected 0", i, rsp_valid[1]);
         end
      end
      // A request presented together with flush must not be taken.
      req_valid[1] = 1'b1; req_addr[1] = 32'h8; flush[1] = 1'b1;
      tick();
      req_valid[1] = 1'b0; flush[1] = 1'b0;
      checks++;
      if (req_ready[1] !== 1'b1 || rsp_valid[1] !== 1'b0) begin
         errors++;
         $display("FAIL flush_gate: ready=%b valid=%b expected 1/0", req_ready[1], rsp_valid[1]);
      end
      for (int i = 0; i < 3; i++) tick();
      checks++;
      if (rsp_valid[1] !== 1'b0) begin
         errors++;
         $display("FAIL flush_gate_late: rsp_valid=%b expected 0", rsp_valid[1]);
      end
      fetch(1, 32'hC, 32'h00001117, 2'd0, "flush_refetch");
   endtask

   task automatic test_back_to_back();
      req_valid[1] = 1'b1; req_addr[1] = 32'h8; rsp_ready[1] = 1'b1;
      tick();
      req_addr[1] = 32'hC;
      tick();
      tick();
      checks++;
      if (rsp_valid[1] !== 1'b1 || rsp_data[1] !== 32'h00c58633) begin
         errors++;
         $display("FAIL b2b_first: valid=%b data=%h expected 1/00c58633", rsp_valid[1], rsp_data[1]);
      end
      tick();
      checks++;
      if (rsp_valid[1] !== 1'b0 || req_ready[1] !== 1'b1) begin
         errors++;
         $display("FAIL b2b_no_accept_in_hs: valid=%b ready=%b expected 0/1", rsp_valid[1], req_ready[1]);
      end
      tick();
      req_valid[1] = 1'b0;
      checks++;
      if (req_ready[1] !== 1'b0) begin
         errors++;
         $display("FAIL b2b_second_accept: ready=%b expected 0", req_ready[1]);
      end
      tick();
      tick();
      checks++;
      if (rsp_valid[1] !== 1'b1 || rsp_data[1] !== 32'h00001117) begin
         errors++;
         $display("FAIL b2b_second: valid=%b data=%h expected 1/00001117", rsp_valid[1], rsp_data[1]);
      end
      tick();
   endtask

   task automatic test_write_first();
      // Same-edge write and sample with no wait states.
      req_valid[0] = 1'b1; req_addr[0] = 32'h14; rsp_ready[0] = 1'b1;
      prog_we[0] = 1'b1; prog_addr[0] = 6'd5; prog_data[0] = 32'h02a00513;
      tick();
      req_valid[0] = 1'b0; prog_we[0] = 1'b0;
      checks++;
      if (rsp_valid[0] !== 1'b1 || rsp_data[0] !== 32'h02a00513) begin
         errors++;
         $display("FAIL wf_ws0: valid=%b data=%h expected 1/02a00513", rsp_valid[0], rsp_data[0]);
      end
      tick();
      // Write landing on the edge that enters RESP after three wait states.
      prog(2, 6'd3, 32'h11111111);
      req_valid[2] = 1'b1; req_addr[2] = 32'hC; rsp_ready[2] = 1'b0;
      tick();
      req_valid[2] = 1'b0;
      tick();
      tick();
      prog_we[2] = 1'b1; prog_addr[2] = 6'd3; prog_data[2] = 32'h00A08193;
      tick();
      prog_we[2] = 1'b0;
      checks++;
      if (rsp_valid[2] !== 1'b1 || rsp_data[2] !== 32'h00A08193) begin
         errors++;
         $display("FAIL wf_sample_edge: valid=%b data=%h expected 1/00a08193", rsp_valid[2], rsp_data[2]);
      end
      prog(2, 6'd3, 32'hDEADBEEF);
      checks++;
      if (rsp_valid[2] !== 1'b1 || rsp_data[2] !== 32'h00A08193) begin
         errors++;
         $display("FAIL wf_after_sample: valid=%b data=%h expected 1/00a08193", rsp_valid[2], rsp_data[2]);
      end
      rsp_ready[2] = 1'b1;
      tick();
      fetch(2, 32'hC, 32'hDEADBEEF, 2'd0, "wf_refetch");
   endtask

   task automatic test_reset_mid_fetch();
      prog(2, 6'd7, 32'h00700393);
      req_valid[2] = 1'b1; req_addr[2] = 32'h1C; rsp_ready[2] = 1'b1;
      tick();
      req_valid[2] = 1'b0;
      tick();
      #2 reset = 1'b1;
      #1;
      checks++;
      if (rsp_valid[2] !== 1'b0 || req_ready[2] !== 1'b1) begin
         errors++;
         $display("FAIL rst_async: valid=%b ready=%b expected 0/1", rsp_valid[2], req_ready[2]);
      end
      checks++;
      if (rsp_data[2] !== 32'h0 || rsp_err[2] !== 2'd0) begin
         errors++;
         $display("FAIL rst_async_rsp: data=%h err=%0d expected 0/0", rsp_data[2], rsp_err[2]);
      end
      tick();
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (rsp_valid[2] !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_late_rsp%0d: rsp_valid=%b expected 0", i, rsp_valid[2]);
         end
      end
      fetch(2, 32'h1C, 32'h00700393, 2'd0, "rst_refetch");
      fetch(1, 32'h8, 32'h00c58633, 2'd0, "rst_refetch_ws2");
   endtask

   initial begin
      test_reset();
      test_basic_fetch();
      test_stall();
      test_faults();
      test_flush();
      test_back_to_back();
      test_write_first();
      test_reset_mid_fetch();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
